// File: rtl/decode_stage.sv
// decode_stage: RV32 OP/OP-IMM decode with 32x32 regfile and issue scoreboard.
// Optional DECODE_WB_BYPASS_EN forwards wb_data into a hazarding source in the write-back cycle.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_inst,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y,
  output logic            alu_sel,
  output logic [4:0]      rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_sb_nxt;
  logic [6:0]       w_op;
  logic [4:0]       w_rs1, w_rs2, w_rd;
  logic             w_is_r, w_is_i, w_legal, w_hz, w_acc, w_byp1, w_byp2;
  logic [XLEN-1:0]  w_imm, w_x, w_y;

  assign w_op    = in_inst[6:0];
  assign w_rd    = in_inst[11:7];
  assign w_rs1   = in_inst[19:15];
  assign w_rs2   = in_inst[24:20];
  assign w_is_r  = w_op == 7'b0110011;
  assign w_is_i  = w_op == 7'b0010011;
  assign w_legal = w_is_r || w_is_i;
  assign w_imm   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};

`ifdef DECODE_WB_BYPASS_EN
  assign w_byp1 = wb_en && wb_rd == w_rs1;
  assign w_byp2 = wb_en && wb_rd == w_rs2;
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // Illegal opcodes never stall; they are dropped as soon as the output slot frees.
  assign w_hz = w_legal && ((w_rs1 != 5'd0 && r_sb[w_rs1] && !w_byp1) ||
                            (w_is_r && w_rs2 != 5'd0 && r_sb[w_rs2] && !w_byp2));
  assign in_ready = (!out_valid || out_ready) && !w_hz;
  assign w_acc    = in_valid && in_ready;
  assign w_x = (w_rs1 == 5'd0) ? '0 : w_byp1 ? wb_data : r_regs[w_rs1];
  assign w_y = w_is_i ? w_imm : (w_rs2 == 5'd0) ? '0 : w_byp2 ? wb_data : r_regs[w_rs2];

  // Issue set is applied after write-back clear so a same-register collision stays busy.
  always_comb begin
    w_sb_nxt = r_sb;
    if (wb_en) w_sb_nxt[wb_rd] = 1'b0;
    if (w_acc && w_legal && w_rd != 5'd0) w_sb_nxt[w_rd] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      funct3    <= '0;
      funct7    <= '0;
      x         <= '0;
      y         <= '0;
      alu_sel   <= 1'b0;
      rd        <= '0;
      r_sb      <= '0;
    end else begin
      out_valid <= (w_acc && w_legal) || (out_valid && !out_ready);
      illegal   <= w_acc && !w_legal;
      r_sb      <= w_sb_nxt;
      if (w_acc && w_legal) begin
        funct3  <= in_inst[14:12];
        funct7  <= in_inst[31:25];
        x       <= w_x;
        y       <= w_y;
        alu_sel <= w_is_i;
        rd      <= w_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_decode_stage;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] x, y;
  logic        alu_sel;
  logic [4:0]  rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        illegal;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_valid, m_ill, m_sel, m_rdy, m_acc, m_legal;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [31:0] m_x, m_y, p_x, p_y;
  logic [4:0]  m_rd;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .funct3(funct3), .funct7(funct7),
    .x(x), .y(y), .alu_sel(alu_sel), .rd(rd), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal)
  );

  task automatic mreset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_valid = 0; m_ill = 0; m_sel = 0; m_f3 = '0; m_f7 = '0; m_x = '0; m_y = '0; m_rd = '0;
  endtask

  function automatic logic [31:0] rdval(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (BYP && wb_en && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit waits(logic [4:0] r);
    return r != 5'd0 && m_busy[r] && !(BYP && wb_en && wb_rd == r);
  endfunction

  // Drive one cycle's inputs and predict readiness and the operands that would be captured.
  task automatic apply(bit iv, logic [31:0] inst, bit ordy, bit wbe, logic [4:0] wr, logic [31:0] wd);
    bit isr;
    in_valid = iv; in_inst = inst; out_ready = ordy; wb_en = wbe; wb_rd = wr; wb_data = wd;
    isr = inst[6:0] == 7'h33;
    m_legal = isr || inst[6:0] == 7'h13;
    m_rdy = (!m_valid || ordy) && !(m_legal && (waits(inst[19:15]) || (isr && waits(inst[24:20]))));
    m_acc = iv && m_rdy;
    p_x = rdval(inst[19:15]);
    p_y = isr ? rdval(inst[24:20]) : 32'($signed(inst[31:20]));
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_acc && m_legal) begin
      m_valid = 1; m_x = p_x; m_y = p_y; m_f3 = in_inst[14:12]; m_f7 = in_inst[31:25];
      m_sel = in_inst[6:0] == 7'h13; m_rd = in_inst[11:7];
    end else if (out_ready) m_valid = 0;
    m_ill = m_acc && !m_legal;
    if (wb_en) m_busy[wb_rd] = 0;
    if (m_acc && m_legal && in_inst[11:7] != 5'd0) m_busy[in_inst[11:7]] = 1;
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    #1;
  endtask

  task automatic idle();
    apply(0, 32'h0, 1, 0, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    mreset();
    #3;
    n_chk++; if ({out_valid, illegal, alu_sel, funct3, funct7, rd, x, y} !== '0) begin n_fail++; $display("FAIL reset_outputs got v=%b ill=%b sel=%b f3=%h f7=%h rd=%0d x=%h y=%h want all zero", out_valid, illegal, alu_sel, funct3, funct7, rd, x, y); end
    #10 rst_n = 1'b1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    apply(1, 32'hFFB00093, 1, 0, 5'd0, 32'h0);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got %b want 1", in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", out_valid); end
    n_chk++; if ({alu_sel, funct3, rd} !== {1'b1, 3'd0, 5'd1}) begin n_fail++; $display("FAIL addi_ctl got sel=%b f3=%0d rd=%0d want sel=1 f3=0 rd=1", alu_sel, funct3, rd); end
    n_chk++; if (x !== 32'h0 || y !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_ops got x=%h y=%h want x=0 y=fffffffb", x, y); end
    idle();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b want 0", out_valid); end
  endtask

  task automatic test_rtype();
    apply(0, 32'h0, 1, 1, 5'd2, 32'd7); tick();
    apply(0, 32'h0, 1, 1, 5'd3, 32'd9); tick();
    apply(1, 32'h00310233, 1, 0, 5'd0, 32'h0);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got %b want 1", in_ready); end
    tick();
    n_chk++; if (x !== 32'd7 || y !== 32'd9) begin n_fail++; $display("FAIL add_ops got x=%h y=%h want x=7 y=9", x, y); end
    n_chk++; if ({out_valid, alu_sel, funct7, rd} !== {1'b1, 1'b0, 7'd0, 5'd4}) begin n_fail++; $display("FAIL add_ctl got v=%b sel=%b f7=%h rd=%0d want v=1 sel=0 f7=0 rd=4", out_valid, alu_sel, funct7, rd); end
    idle();
  endtask

  task automatic test_back_to_back();
    apply(1, 32'h00100293, 1, 0, 5'd0, 32'h0); tick();
    n_chk++; if (out_valid !== 1'b1 || y !== 32'd1 || rd !== 5'd5) begin n_fail++; $display("FAIL b2b_first got v=%b y=%h rd=%0d want v=1 y=1 rd=5", out_valid, y, rd); end
    for (int i = 0; i < 2; i++) begin
      apply(1, 32'h00528333, 1, 0, 5'd0, 32'h0);
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall%0d got in_ready=%b want 0", i, in_ready); end
      tick();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_hold%0d got out_valid=%b want 0", i, out_valid); end
    end
    apply(1, 32'h00528333, 1, 1, 5'd5, 32'd1);
    n_chk++; if (in_ready !== BYP) begin n_fail++; $display("FAIL b2b_wb_cycle got in_ready=%b want %b", in_ready, BYP); end
    tick();
    if (!BYP) begin
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_wb_noissue got out_valid=%b want 0", out_valid); end
      apply(1, 32'h00528333, 1, 0, 5'd0, 32'h0);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_after_wb got in_ready=%b want 1", in_ready); end
      tick();
    end
    n_chk++; if ({out_valid, rd, x, y} !== {1'b1, 5'd6, 32'd1, 32'd1}) begin n_fail++; $display("FAIL b2b_issue got v=%b rd=%0d x=%h y=%h want v=1 rd=6 x=1 y=1", out_valid, rd, x, y); end
    idle();
  endtask

  task automatic test_backpressure();
    apply(1, 32'h12300413, 1, 0, 5'd0, 32'h0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 32'h00500493, 0, 0, 5'd0, 32'h0);
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got %b want 0", i, in_ready); end
      tick();
      n_chk++; if ({out_valid, rd, y, x} !== {1'b1, 5'd8, 32'h123, 32'h0}) begin n_fail++; $display("FAIL bp_hold%0d got v=%b rd=%0d y=%h x=%h want v=1 rd=8 y=123 x=0", i, out_valid, rd, y, x); end
    end
    apply(1, 32'h00500493, 1, 0, 5'd0, 32'h0);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
    tick();
    n_chk++; if ({out_valid, rd, y} !== {1'b1, 5'd9, 32'd5}) begin n_fail++; $display("FAIL bp_next got v=%b rd=%0d y=%h want v=1 rd=9 y=5", out_valid, rd, y); end
    idle();
  endtask

  task automatic test_illegal();
    apply(1, 32'h00000003, 1, 0, 5'd0, 32'h0);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready got %b want 1", in_ready); end
    tick();
    n_chk++; if (illegal !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_pulse got ill=%b v=%b want ill=1 v=0", illegal, out_valid); end
    apply(1, 32'h00000383, 1, 0, 5'd0, 32'h0); tick();
    n_chk++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_rd7 got %b want 1", illegal); end
    apply(1, 32'h00738533, 1, 0, 5'd0, 32'h0);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_no_sb got in_ready=%b want 1", in_ready); end
    tick();
    n_chk++; if ({illegal, out_valid, rd, x} !== {1'b0, 1'b1, 5'd10, 32'h0}) begin n_fail++; $display("FAIL ill_after got ill=%b v=%b rd=%0d x=%h want ill=0 v=1 rd=10 x=0", illegal, out_valid, rd, x); end
    idle();
  endtask

  task automatic test_x0_reset();
    apply(0, 32'h0, 1, 1, 5'd0, 32'hDEADBEEF); tick();
    apply(1, 32'h000003B3, 1, 0, 5'd0, 32'h0); tick();
    n_chk++; if ({out_valid, rd, x, y} !== {1'b1, 5'd7, 32'h0, 32'h0}) begin n_fail++; $display("FAIL x0_read got v=%b rd=%0d x=%h y=%h want v=1 rd=7 x=0 y=0", out_valid, rd, x, y); end
    apply(1, 32'h007385B3, 0, 0, 5'd0, 32'h0);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b want 0", in_ready); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({out_valid, illegal, alu_sel, funct3, funct7, rd, x, y} !== '0) begin n_fail++; $display("FAIL midreset_outputs got v=%b rd=%0d x=%h y=%h f3=%h f7=%h want all zero", out_valid, rd, x, y, funct3, funct7); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", in_ready); end
    @(posedge clk); #3;
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    mreset();
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postreset_valid got %b want 0", out_valid); end
    apply(1, 32'h00310633, 1, 0, 5'd0, 32'h0);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL postreset_ready got %b want 1", in_ready); end
    tick();
    n_chk++; if ({out_valid, x, y} !== {1'b1, 32'h0, 32'h0}) begin n_fail++; $display("FAIL postreset_regs got v=%b x=%h y=%h want v=1 x=0 y=0", out_valid, x, y); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] inst;
    logic [4:0]  r;
    int k;
    bit wbe;
    for (int c = 0; c < 600; c++) begin
      inst = $urandom;
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      inst[11:7]  = 5'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      inst[6:0] = (k < 5) ? 7'h33 : (k < 9) ? 7'h13 : (k == 9 && inst[0]) ? 7'h03 : 7'h63;
      r = 5'($urandom_range(0, 7));
      wbe = ($urandom_range(0, 3) == 0) || (m_busy[r] && $urandom_range(0, 1) == 1);
      apply($urandom_range(0, 3) != 0, inst, $urandom_range(0, 3) != 0, wbe, r, $urandom);
      n_chk++; if (in_ready !== m_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, in_ready, m_rdy); end
      tick();
      n_chk++; if (out_valid !== m_valid || illegal !== m_ill) begin n_fail++; $display("FAIL rnd_flags c=%0d got v=%b ill=%b want v=%b ill=%b", c, out_valid, illegal, m_valid, m_ill); end
      if (m_valid) begin
        n_chk++; if ({funct3, funct7, x, y, alu_sel, rd} !== {m_f3, m_f7, m_x, m_y, m_sel, m_rd}) begin n_fail++; $display("FAIL rnd_bundle c=%0d got f3=%h f7=%h x=%h y=%h sel=%b rd=%0d want f3=%h f7=%h x=%h y=%h sel=%b rd=%0d", c, funct3, funct7, x, y, alu_sel, rd, m_f3, m_f7, m_x, m_y, m_sel, m_rd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_x0_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
